// File: rtl/cam_emulator_pkg.sv
// Shared types and the pattern generator for the camera-bus emulator.
// Pixel values are truncated to 12 bits.
package camerica_pkg;

    localparam int PIX_W = 12;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_DIAG  = 2'd3
    } pattern_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Pixel value for position (x,y) of a frame; all arithmetic wraps at PIX_W bits.
    function automatic logic [PIX_W-1:0] pix_value(
        input pattern_t    pat,
        input logic [15:0] x,
        input logic [15:0] y,
        input logic [15:0] fc
    );
        logic [PIX_W-1:0] v;
        case (pat)
            PAT_HRAMP: v = x[PIX_W-1:0];
            PAT_VRAMP: v = y[PIX_W-1:0];
            PAT_CHECK: v = {PIX_W{x[0] ^ y[0]}};
            PAT_DIAG:  v = x[PIX_W-1:0] + y[PIX_W-1:0] + fc[PIX_W-1:0];
            default:   v = {PIX_W{1'b0}};
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cam_emulator_if.sv
// Camera bus: divided pixel clock, pixel data and the two valid strobes.
interface cam_emulator_if;
    import camerica_pkg::*;

    logic             cam_clk;
    logic [PIX_W-1:0] cam_pixel;
    logic             cam_hsync;
    logic             cam_vsync;

    modport master (output cam_clk, output cam_pixel, output cam_hsync, output cam_vsync);
    modport slave  (input  cam_clk, input  cam_pixel, input  cam_hsync, input  cam_vsync);

endinterface

// File: rtl/cam_clkgen.sv
// Free-running divider: cam_clk toggles every CLK_DIV clk cycles; fall_tick
// marks the clk cycle whose closing edge takes cam_clk from 1 to 0.
module cam_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    output logic cam_clk,
    output logic fall_tick
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic             cam_clk_r;
    logic             half_end_s;

    // End of the current cam_clk half-period.
    always_comb begin
        half_end_s = (div_cnt_r == DIV_LAST);
    end

    assign fall_tick = half_end_s & cam_clk_r;
    assign cam_clk   = cam_clk_r;

    // Half-period counter and the divided clock itself.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt_r <= {DIV_W{1'b0}};
            cam_clk_r <= 1'b0;
        end else if (half_end_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
            cam_clk_r <= ~cam_clk_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/cam_emulator.sv
// Camera-bus transmitter: raster counters, frame FSM and pattern mux.
// Every bus output is registered and changes only on the cam_clk falling edge.
module cam_emulator
    import camerica_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_BLANK  = 45
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            pattern,
    output logic [15:0]           frame_count,
    output logic                  running,
    cam_emulator_if.master        cam
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    localparam logic [XW-1:0] X_ACT  = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_ACT  = YW'(V_ACTIVE);

    logic             cam_clk_s;
    logic             fall_tick_s;

    state_t           state_r;
    logic [XW-1:0]    x_r;
    logic [YW-1:0]    y_r;
    pattern_t         pat_r;
    logic [15:0]      frame_count_r;
    logic             running_r;
    logic [PIX_W-1:0] pixel_r;
    logic             hsync_r;
    logic             vsync_r;

    logic             frame_end_s;
    logic             start_s;
    logic [XW-1:0]    nx_s;
    logic [YW-1:0]    ny_s;
    logic [15:0]      fc_next_s;
    pattern_t         pat_next_s;
    logic             vsync_next_s;
    logic             hsync_next_s;
    logic [PIX_W-1:0] pixel_next_s;

    cam_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .cam_clk   (cam_clk_s),
        .fall_tick (fall_tick_s)
    );

    // Next raster position, frame start/end decisions and the pixel to drive there.
    always_comb begin
        frame_end_s  = (x_r == X_LAST) && (y_r == Y_LAST);
        start_s      = 1'b0;
        fc_next_s    = frame_count_r;
        nx_s         = {XW{1'b0}};
        ny_s         = {YW{1'b0}};
        pat_next_s   = pat_r;
        pixel_next_s = {PIX_W{1'b0}};

        case (state_r)
            IDLE: start_s = enable;
            RUN: begin
                if (frame_end_s) begin
                    start_s   = enable;
                    fc_next_s = frame_count_r + 16'd1;
                end else begin
                    start_s   = 1'b0;
                end
            end
            default: start_s = 1'b0;
        endcase

        // A new frame re-latches the pattern; otherwise walk the raster.
        if (start_s) begin
            nx_s       = {XW{1'b0}};
            ny_s       = {YW{1'b0}};
            pat_next_s = pattern_t'(pattern);
        end else if (x_r == X_LAST) begin
            nx_s       = {XW{1'b0}};
            ny_s       = y_r + YW'(1);
            pat_next_s = pat_r;
        end else begin
            nx_s       = x_r + XW'(1);
            ny_s       = y_r;
            pat_next_s = pat_r;
        end

        vsync_next_s = (ny_s < Y_ACT);
        hsync_next_s = vsync_next_s && (nx_s < X_ACT);

        if (hsync_next_s) begin
            pixel_next_s = pix_value(pat_next_s, 16'(nx_s), 16'(ny_s), fc_next_s);
        end else begin
            pixel_next_s = {PIX_W{1'b0}};
        end
    end

    // Frame FSM with raster counters and registered bus outputs, advanced on fall_tick.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            x_r           <= {XW{1'b0}};
            y_r           <= {YW{1'b0}};
            pat_r         <= PAT_HRAMP;
            frame_count_r <= 16'd0;
            running_r     <= 1'b0;
            pixel_r       <= {PIX_W{1'b0}};
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
        end else if (fall_tick_s) begin
            frame_count_r <= fc_next_s;
            if (start_s) begin
                state_r   <= RUN;
                running_r <= 1'b1;
                x_r       <= nx_s;
                y_r       <= ny_s;
                pat_r     <= pat_next_s;
                pixel_r   <= pixel_next_s;
                hsync_r   <= hsync_next_s;
                vsync_r   <= vsync_next_s;
            end else if ((state_r == RUN) && !frame_end_s) begin
                x_r       <= nx_s;
                y_r       <= ny_s;
                pixel_r   <= pixel_next_s;
                hsync_r   <= hsync_next_s;
                vsync_r   <= vsync_next_s;
            end else begin
                // Idle, or a frame just finished with enable low: park with the bus quiet.
                state_r   <= IDLE;
                running_r <= 1'b0;
                x_r       <= {XW{1'b0}};
                y_r       <= {YW{1'b0}};
                pixel_r   <= {PIX_W{1'b0}};
                hsync_r   <= 1'b0;
                vsync_r   <= 1'b0;
            end
        end
    end

    assign frame_count   = frame_count_r;
    assign running       = running_r;
    assign cam.cam_clk   = cam_clk_s;
    assign cam.cam_pixel = pixel_r;
    assign cam.cam_hsync = hsync_r;
    assign cam.cam_vsync = vsync_r;

endmodule

// File: tb/tb_cam_emulator.sv
// Scoreboard bench for cam_emulator on a 12x6 raster (8x4 active).
module tb_cam_emulator;
    import camerica_pkg::*;

    localparam int CLK_DIV  = 2;
    localparam int H_ACTIVE = 8;
    localparam int H_BLANK  = 4;
    localparam int V_ACTIVE = 4;
    localparam int V_BLANK  = 2;
    localparam int H_TOTAL  = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL  = V_ACTIVE + V_BLANK;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern = 2'd0;
    logic [15:0] frame_count;
    logic        running;

    cam_emulator_if cam_bus ();

    cam_emulator #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern     (pattern),
        .frame_count (frame_count),
        .running     (running),
        .cam         (cam_bus)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        vs;
        logic        hs;
        logic [11:0] pix;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    function automatic logic [11:0] model_pix(input int pat, input int x, input int y, input int fc);
        case (pat)
            0:       return 12'(x);
            1:       return 12'(y);
            2:       return ((x % 2) != (y % 2)) ? 12'hFFF : 12'h000;
            default: return 12'(x + y + fc);
        endcase
    endfunction

    task automatic push_frame(input int pat, input int fc);
        exp_t e;
        for (int y = 0; y < V_TOTAL; y++) begin
            for (int x = 0; x < H_TOTAL; x++) begin
                e.vs  = (y < V_ACTIVE);
                e.hs  = (y < V_ACTIVE) && (x < H_ACTIVE);
                e.pix = e.hs ? model_pix(pat, x, y, fc) : 12'h000;
                e.fc  = 16'(fc);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_running(input int budget);
        for (int i = 0; i < budget && !running; i++) @(negedge clk);
        check("running_start", 32'(running), 32'd1);
    endtask

    task automatic wait_fc(input int target, input int budget);
        for (int i = 0; i < budget && frame_count != 16'(target); i++) @(negedge clk);
        check("frame_count_reach", 32'(frame_count), 32'(target));
    endtask

    task automatic check_quiet(input string name);
        check(name, {cam_bus.cam_vsync, cam_bus.cam_hsync, running, 17'd0, cam_bus.cam_pixel}, 32'd0);
    endtask

    // Monitor: each cam_clk rise while running is one pixel time.
    always begin
        exp_t e;
        @(posedge cam_bus.cam_clk);
        #1;
        if (running) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("pixel", 32'({cam_bus.cam_vsync, cam_bus.cam_hsync, cam_bus.cam_pixel, frame_count}),
                      32'(e));
            end
        end
    end

    initial begin
        int   t0;
        logic activity;

        // Reset state
        rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_cam_clk", 32'(cam_bus.cam_clk), 32'd0);
        check("rst_pixel", 32'(cam_bus.cam_pixel), 32'd0);
        check("rst_hsync", 32'(cam_bus.cam_hsync), 32'd0);
        check("rst_vsync", 32'(cam_bus.cam_vsync), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);

        // Clock timing after release
        rst = 1'b1;
        @(negedge clk);
        check("cam_clk_edge1", 32'(cam_bus.cam_clk), 32'd0);
        @(negedge clk);
        check("cam_clk_rise2", 32'(cam_bus.cam_clk), 32'd1);
        repeat (2) @(negedge clk);
        check("cam_clk_fall4", 32'(cam_bus.cam_clk), 32'd0);
        repeat (2) @(negedge clk);
        check("cam_clk_rise6", 32'(cam_bus.cam_clk), 32'd1);

        activity = 1'b0;
        repeat (40) begin
            @(negedge clk);
            activity = activity | cam_bus.cam_hsync | cam_bus.cam_vsync | running | (|cam_bus.cam_pixel);
        end
        check("idle_no_activity", 32'(activity), 32'd0);

        // Four back-to-back frames; pattern changes mid-frame take effect next frame
        push_frame(0, 0);
        push_frame(1, 1);
        push_frame(2, 2);
        push_frame(3, 3);
        pattern = 2'd0;
        enable  = 1'b1;
        wait_running(20);
        t0 = cyc;
        pattern = 2'd1;
        wait_fc(1, 400);
        check("frame_cycles", 32'(cyc - t0), 32'd288);
        pattern = 2'd2;
        wait_fc(2, 400);
        pattern = 2'd3;
        wait_fc(3, 400);

        // Drop enable at pixel (3,1) of the last frame
        repeat (15) @(negedge cam_bus.cam_clk);
        #1;
        enable = 1'b0;
        wait_fc(4, 400);
        check_quiet("after_frame_quiet");
        check("queue_drained_1", 32'(exp_q.size()), 32'd0);
        activity = 1'b0;
        repeat (40) begin
            @(negedge clk);
            activity = activity | cam_bus.cam_hsync | cam_bus.cam_vsync | running;
        end
        check("stays_idle", 32'(activity), 32'd0);
        check("frame_count_held", 32'(frame_count), 32'd4);

        // Restart, then reset at pixel (5,2)
        push_frame(0, 4);
        pattern = 2'd0;
        enable  = 1'b1;
        wait_running(20);
        repeat (29) @(negedge cam_bus.cam_clk);
        #1;
        check("pixel_5_2", 32'(cam_bus.cam_pixel), 32'd5);
        check("hsync_5_2", 32'(cam_bus.cam_hsync), 32'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_quiet("midframe_rst_quiet");
        check("midframe_rst_fc", 32'(frame_count), 32'd0);
        check("midframe_rst_cam_clk", 32'(cam_bus.cam_clk), 32'd0);
        exp_q.delete();

        // Clean frame after reset
        push_frame(0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wait_running(20);
        enable = 1'b0;
        wait_fc(1, 400);
        check_quiet("final_quiet");
        check("queue_drained_2", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_emulator.md
Name: cam_emulator

Overview:
- Synthesizable camera-bus transmitter. Drives cam_clk, cam_pixel, cam_hsync and cam_vsync with the same electrical and timing convention that the camera-bus receiver consumes.
- Generates programmable test patterns so the retiming and capture path can be exercised on hardware and in simulation without a physical camera.
- Runs entirely in the 50 MHz main clock domain; cam_clk is derived by division.

Parameters:
- CLK_DIV, 2: clk cycles per cam_clk half-period (>=1).
- H_ACTIVE, 640: active pixels per line.
- H_BLANK, 160: blank pixel times per line (>=1).
- V_ACTIVE, 480: active lines per frame.
- V_BLANK, 45: blank lines per frame (>=1).

Ports:
- clk  in  1  50 MHz main clock.
- rst  in  1  reset; synchronous, active-low.
- enable  in  1  request frames; sampled only at frame boundaries.
- pattern  in  2  pattern select; latched at frame start.
- frame_count  out  16  completed frames, wraps at 16 bits.
- running  out  1  high while a frame is being emitted.
- cam_clk  out  1  divided pixel clock.
- cam_pixel  out  12  pixel data.
- cam_hsync  out  1  line valid: high during the active pixels of an active line.
- cam_vsync  out  1  frame valid: high for the whole of the active lines (blank pixels included).

Behaviour:
- Reset (rst=0 at a clk edge): cam_clk=0, cam_pixel=0, cam_hsync=0, cam_vsync=0, running=0, frame_count=0, x=y=0, div counter=0, state IDLE. Takes effect at the same edge, including mid-frame.
- Clock generation: cam_clk toggles every CLK_DIV clk cycles and free-runs from reset.
  - fall_tick: the clk cycle in which cam_clk goes 1->0.
  - Period = 2*CLK_DIV clk cycles.
  - First rise occurs CLK_DIV cycles after reset release.
- Update rule: all cam_* data and sync outputs change only on fall_tick, so they are stable around the cam_clk rising edge where the receiver samples.
- State machine:
  - IDLE: outputs low. On fall_tick with enable=1:
    - go to RUN with x=y=0;
    - latch pattern into pat_q;
    - drive pixel (0,0) on that same tick;
    - running=1.
  - RUN: each fall_tick advances x. When x = H_TOTAL-1, x wraps to 0 and y increments (H_TOTAL = H_ACTIVE+H_BLANK, V_TOTAL = V_ACTIVE+V_BLANK).
  - End of frame (x=H_TOTAL-1, y=V_TOTAL-1): on the next fall_tick, frame_count increments, then:
    - if enable=1, restart at (0,0) with a new pattern latch;
    - else go to IDLE with running=0 and outputs low.
- Outputs for position (x,y), registered on the tick:
  - cam_vsync = (y < V_ACTIVE).
  - cam_hsync = (y < V_ACTIVE) && (x < H_ACTIVE).
  - cam_pixel = 0 unless cam_hsync is high.
- Patterns (12-bit, truncating):
  - 0: x[11:0] (horizontal ramp).
  - 1: y[11:0] (vertical ramp).
  - 2: {12{x[0]^y[0]}} (checker).
  - 3: x+y+frame_count[11:0] (moving diagonal).
- Deasserting enable mid-frame has no effect until the frame completes. Pattern changes mid-frame are ignored.
- Counter widths: clog2 of the totals. frame_count wraps 16'hFFFF->0.

Decomposition:
- camerica_pkg:
  - PIX_W=12;
  - typedef enum logic [1:0] pattern_t {PAT_HRAMP, PAT_VRAMP, PAT_CHECK, PAT_DIAG};
  - typedef enum state_t {IDLE, RUN}.
- Sub-module cam_clkgen: CLK_DIV divider producing cam_clk and a one-cycle fall_tick strobe, same reset.
- Top holds the counters, FSM and pattern mux.

Test Plan:
All scenarios use CLK_DIV=2, H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_BLANK=2.
- Reset: hold rst=0 for 5 clk -> all outputs 0. After release, cam_clk rises at clk 2 with period 4, and the first fall_tick follows 2 clk later. Confirm no sync activity while enable=0.
- Ramp frame (enable=1, pattern=0), sampled on cam_clk rise:
  - each active line carries 0,1,...,7;
  - hsync high 8 / low 4 pixel times;
  - vsync high 48 / low 24 pixel times;
  - frame_count reaches 1 after 72 pixel times (288 clk).
- Checker (pattern=2): line 0 reads 000,FFF,000,...; line 1 reads FFF,000,... Pixel is 0 during blank.
- Enable dropped at pixel (3,1): frame completes all 72 pixel times, frame_count goes 0->1, then running=0 and outputs stay low. Re-asserting enable starts a new frame from (0,0).
- Pattern switched 0->1 mid-frame: the current frame remains a horizontal ramp; the next frame shows line y constant at y.
- rst=0 asserted at pixel (5,2): all outputs 0 at the next clk edge. After release, the next frame starts cleanly at (0,0) with frame_count=0.
